ps2_key_event_decoder: RTL and testbench
========================================

// Module: ps2_key_event_decoder
// PURPOSE
//  Parametrised successor to the PS/2 set-2 scan-code-to-ASCII translator. Consumes byte strobes from the
//  PS/2 receiver and emits complete key events: press/release, extended flag, raw scan code and ASCII.
//  Adds Ctrl/Alt tracking, typematic-repeat filtering, E1 (Pause) swallowing and an output event FIFO
//  with a valid/ready handshake. Sits between the PS/2 receiver and the game/UI logic.
// PARAMETERS
//  FIFO_DEPTH     8  event FIFO entries; power of 2, >=2
//  EMIT_RELEASE   1  1: release events are queued; 0: only press events are queued
//  REPEAT_FILTER  1  1: drop typematic makes of the currently held key; 0: queue every make
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  ps2_code_new  in   1   level from receiver; a rising edge marks a new byte
//  ps2_code      in   8   received byte; stable while ps2_code_new is high
//  evt_valid     out  1   FIFO head holds an event
//  evt_ready     in   1   consumer accepts head when evt_valid & evt_ready
//  evt_release   out  1   head: 1 = break, 0 = make
//  evt_ext       out  1   head: E0-prefixed key
//  evt_scan      out  8   head: scan code without prefixes
//  evt_ascii     out  8   head: translated character, 8'h00 if unmapped
//  mods          out  4   {capslock, alt, ctrl, shift}, live state
//  fifo_level    out  $clog2(FIFO_DEPTH)+1  current occupancy
//  overflow      out  1   one-cycle pulse when an event is dropped because the FIFO is full
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; mods 0; held-key register invalid; FIFO empty.
//  Byte strobe = ps2_code_new & ~ps2_code_new_q (one cycle per edge); every byte is processed on its strobe.
//  FSM: IDLE  -E0-> EXT; -F0-> BRK; -E1-> SKIP (cnt=7); other byte -> finish make, stay IDLE
//       EXT   -F0-> EXT_BRK; other byte -> finish ext make -> IDLE
//       BRK   -byte-> finish break -> IDLE;  EXT_BRK -byte-> finish ext break -> IDLE
//       SKIP  each byte decrements cnt; at cnt==1 -> IDLE; no events (whole Pause sequence dropped)
//       Repeated E0 in EXT or E0 in BRK -> EXT/EXT_BRK (tolerated, no error).
//  Modifiers (not queued): 12/59 shift, 14 ctrl, 11 alt (ext or not); make sets, break clears the bit.
//   E0 12 and E0 59 (fake shifts) are ignored entirely. 58 caps: toggles capslock on a make only when
//   caps is not already held; break clears held flag.
//  Repeat filter: held = {ext,scan} of last non-modifier make. Make equal to held -> dropped when
//   REPEAT_FILTER=1. Break equal to held -> held invalidated. Other breaks leave held unchanged.
//  ASCII: ext keys -> {1'b1, scan[6:0]}; 76 esc 1B, 66 bksp 08, 5A ret 0D, 29 space 20, 0D tab 09;
//   letters: upper iff shift^capslock; digits/punctuation: shifted glyph iff shift (capslock ignored);
//   ctrl held and letter -> 8'h01..8'h1A (ctrl beats shift/caps). Mods sampled before the current byte.
//  Latency: final byte strobe at cycle N -> event written to FIFO at N+1 -> evt_valid at N+2 (if empty).
//  FIFO: first-word-fall-through; outputs reflect head. Push while full and no pop -> event dropped,
//   overflow pulses. Push and pop in the same cycle while full -> both succeed, level unchanged.
//   Pop when empty ignored. Level wraps never; pointers wrap modulo FIFO_DEPTH.
//  Reset mid-sequence (e.g. after F0) discards partial sequence; next byte is decoded from IDLE.
//  Unmapped non-modifier keys still queue an event with evt_ascii = 00.
// STRUCTURE
//  ps2_pkg: scan-code constants (E0, E1, F0, modifier codes), FSM state enum, event record
//   {release, ext, scan[7:0], ascii[7:0]} and its width constant (18).
//  Sub-module ps2_ascii_lut: combinational {ext, scan, shift, caps, ctrl} -> ascii[7:0].
//  FIFO held locally (reg array + pointers); no separate module.
// TESTING
//  1C, F0 1C with ready=1 -> press{ascii 61,scan 1C} then release{ascii 61}; level peaks at 1.
//  12, 1C, 1C, 1C, F0 1C, F0 12 (REPEAT_FILTER=1) -> one press 41, one release 41; shift back to 0.
//  58, F0 58, 1C; then 14, 1C -> caps=1, press 41; ctrl held -> press ascii 01.
//  E0 75, E0 F0 75 -> press/release ext=1, scan 75, ascii F5; E1 14 77 E1 F0 14 F0 77 -> nothing.
//  evt_ready=0, FIFO_DEPTH+1 presses -> level=FIFO_DEPTH, one overflow pulse, head = first event.
//  rst_n low after F0 then byte 1C -> press 61 (partial break discarded), outputs 0 during reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: scan-code constants, decoder state and the queued key-event record
package ps2_pkg;
  localparam logic [7:0] SC_E0 = 8'hE0;
  localparam logic [7:0] SC_E1 = 8'hE1;
  localparam logic [7:0] SC_F0 = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL = 8'h14;
  localparam logic [7:0] SC_ALT = 8'h11;
  localparam logic [7:0] SC_CAPS = 8'h58;
  localparam int EVT_W = 18;
  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_SKIP} state_e;
  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] scan;
    logic [7:0] ascii;
  } evt_t;
endpackage

// File: rtl/ps2_ascii_lut.sv
// ps2_ascii_lut: set-2 scan code plus modifier state to ASCII, 8'h00 when unmapped
module ps2_ascii_lut (
  input  logic       ext_i,
  input  logic [7:0] scan_i,
  input  logic       shift_i,
  input  logic       caps_i,
  input  logic       ctrl_i,
  output logic [7:0] ascii_o
);
  logic [7:0] lo, hi;
  logic letter;
  always_comb begin
    case (scan_i)
      8'h1C: {lo, hi} = {"a", "A"};
      8'h32: {lo, hi} = {"b", "B"};
      8'h21: {lo, hi} = {"c", "C"};
      8'h23: {lo, hi} = {"d", "D"};
      8'h24: {lo, hi} = {"e", "E"};
      8'h2B: {lo, hi} = {"f", "F"};
      8'h34: {lo, hi} = {"g", "G"};
      8'h33: {lo, hi} = {"h", "H"};
      8'h43: {lo, hi} = {"i", "I"};
      8'h3B: {lo, hi} = {"j", "J"};
      8'h42: {lo, hi} = {"k", "K"};
      8'h4B: {lo, hi} = {"l", "L"};
      8'h3A: {lo, hi} = {"m", "M"};
      8'h31: {lo, hi} = {"n", "N"};
      8'h44: {lo, hi} = {"o", "O"};
      8'h4D: {lo, hi} = {"p", "P"};
      8'h15: {lo, hi} = {"q", "Q"};
      8'h2D: {lo, hi} = {"r", "R"};
      8'h1B: {lo, hi} = {"s", "S"};
      8'h2C: {lo, hi} = {"t", "T"};
      8'h3C: {lo, hi} = {"u", "U"};
      8'h2A: {lo, hi} = {"v", "V"};
      8'h1D: {lo, hi} = {"w", "W"};
      8'h22: {lo, hi} = {"x", "X"};
      8'h35: {lo, hi} = {"y", "Y"};
      8'h1A: {lo, hi} = {"z", "Z"};
      8'h45: {lo, hi} = {"0", ")"};
      8'h16: {lo, hi} = {"1", "!"};
      8'h1E: {lo, hi} = {"2", "@"};
      8'h26: {lo, hi} = {"3", "#"};
      8'h25: {lo, hi} = {"4", "$"};
      8'h2E: {lo, hi} = {"5", "%"};
      8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"};
      8'h3E: {lo, hi} = {"8", "*"};
      8'h46: {lo, hi} = {"9", "("};
      8'h0E: {lo, hi} = {8'h60, "~"};
      8'h4E: {lo, hi} = {"-", "_"};
      8'h55: {lo, hi} = {"=", "+"};
      8'h54: {lo, hi} = {"[", "{"};
      8'h5B: {lo, hi} = {"]", "}"};
      8'h5D: {lo, hi} = {"\\", "|"};
      8'h4C: {lo, hi} = {";", ":"};
      8'h52: {lo, hi} = {"'", "\""};
      8'h41: {lo, hi} = {",", "<"};
      8'h49: {lo, hi} = {".", ">"};
      8'h4A: {lo, hi} = {"/", "?"};
      8'h76: {lo, hi} = 16'h1B1B;
      8'h66: {lo, hi} = 16'h0808;
      8'h5A: {lo, hi} = 16'h0D0D;
      8'h29: {lo, hi} = 16'h2020;
      8'h0D: {lo, hi} = 16'h0909;
      default: {lo, hi} = 16'h0000;
    endcase
  end
  assign letter = (lo >= "a") && (lo <= "z");
  // ctrl folds letters onto 01..1A and overrides shift/caps
  assign ascii_o = ext_i ? {1'b1, scan_i[6:0]} :
                   letter ? (ctrl_i ? lo - 8'h60 : (shift_i ^ caps_i) ? lo - 8'h20 : lo) :
                   shift_i ? hi : lo;
endmodule

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: PS/2 set-2 byte stream to queued key events with modifier tracking
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter bit EMIT_RELEASE  = 1'b1,
  parameter bit REPEAT_FILTER = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ps2_code_new,
  input  logic [7:0]                  ps2_code,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic                        evt_release,
  output logic                        evt_ext,
  output logic [7:0]                  evt_scan,
  output logic [7:0]                  evt_ascii,
  output logic [3:0]                  mods,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic new_q, stb;
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic fin, fin_rel, fin_ext;
  logic shift_q, shift_d, ctrl_q, ctrl_d, alt_q, alt_d, caps_q, caps_d, caps_held_q, caps_held_d;
  logic [8:0] held_q, held_d;
  logic held_v_q, held_v_d;
  logic sh_code, is_shift, is_ctrl, is_alt, is_caps, is_mod, is_held;
  logic push_d, push_q;
  logic [7:0] ascii;
  evt_t evt_d, evt_q, head;
  logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] lvl_q;
  logic full, pop, wr, ovf_q;
  assign stb = ps2_code_new & ~new_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      new_q   <= 1'b0;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      new_q   <= ps2_code_new;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (stb)
      case (state_q)
        S_IDLE: begin
          state_d = ps2_code == SC_E0 ? S_EXT : ps2_code == SC_F0 ? S_BRK :
                    ps2_code == SC_E1 ? S_SKIP : S_IDLE;
          cnt_d   = 3'd7;
        end
        S_EXT:   state_d = ps2_code == SC_F0 ? S_EXT_BRK : ps2_code == SC_E0 ? S_EXT : S_IDLE;
        S_BRK:   state_d = ps2_code == SC_E0 ? S_EXT_BRK : S_IDLE;
        S_SKIP: begin
          state_d = cnt_q == 3'd1 ? S_IDLE : S_SKIP;
          cnt_d   = cnt_q - 3'd1;
        end
        default: state_d = S_IDLE;
      endcase
  end
  always_comb begin
    fin_rel = state_q inside {S_BRK, S_EXT_BRK};
    fin_ext = state_q inside {S_EXT, S_EXT_BRK};
    fin     = stb & (state_q == S_IDLE ? !(ps2_code inside {SC_E0, SC_F0, SC_E1}) :
                     state_q == S_EXT  ? !(ps2_code inside {SC_E0, SC_F0}) :
                     state_q == S_BRK  ? ps2_code != SC_E0 :
                     state_q == S_EXT_BRK);
  end
  ps2_ascii_lut u_lut (
    .ext_i  (fin_ext),
    .scan_i (ps2_code),
    .shift_i(shift_q),
    .caps_i (caps_q),
    .ctrl_i (ctrl_q),
    .ascii_o(ascii)
  );
  // E0-prefixed shift codes are fake shifts: counted as modifiers so they are swallowed
  always_comb begin
    sh_code     = ps2_code inside {SC_LSHIFT, SC_RSHIFT};
    is_shift    = sh_code & ~fin_ext;
    is_ctrl     = ps2_code == SC_CTRL;
    is_alt      = ps2_code == SC_ALT;
    is_caps     = (ps2_code == SC_CAPS) & ~fin_ext;
    is_mod      = sh_code | is_ctrl | is_alt | is_caps;
    is_held     = held_v_q & (held_q == {fin_ext, ps2_code});
    shift_d     = fin & is_shift ? ~fin_rel : shift_q;
    ctrl_d      = fin & is_ctrl ? ~fin_rel : ctrl_q;
    alt_d       = fin & is_alt ? ~fin_rel : alt_q;
    caps_d      = fin & is_caps & ~fin_rel & ~caps_held_q ? ~caps_q : caps_q;
    caps_held_d = fin & is_caps ? ~fin_rel : caps_held_q;
    push_d      = fin & ~is_mod & (fin_rel ? EMIT_RELEASE : ~(REPEAT_FILTER & is_held));
    held_d      = fin & ~is_mod & ~fin_rel ? {fin_ext, ps2_code} : held_q;
    held_v_d    = fin & ~is_mod ? (fin_rel ? held_v_q & ~is_held : 1'b1) : held_v_q;
    evt_d       = '{rel: fin_rel, ext: fin_ext, scan: ps2_code, ascii: ascii};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      shift_q     <= 1'b0;
      ctrl_q      <= 1'b0;
      alt_q       <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      held_q      <= '0;
      held_v_q    <= 1'b0;
      push_q      <= 1'b0;
      evt_q       <= '0;
    end else begin
      shift_q     <= shift_d;
      ctrl_q      <= ctrl_d;
      alt_q       <= alt_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      held_q      <= held_d;
      held_v_q    <= held_v_d;
      push_q      <= push_d;
      evt_q       <= evt_d;
    end
  assign full = lvl_q == (AW+1)'(FIFO_DEPTH);
  assign pop  = evt_ready & (lvl_q != '0);
  assign wr   = push_q & (~full | pop);
  always_ff @(posedge clk)
    if (wr) mem_q[wr_q] <= evt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_q + AW'(wr);
      rd_q  <= rd_q + AW'(pop);
      lvl_q <= lvl_q + (AW+1)'(wr) - (AW+1)'(pop);
      ovf_q <= push_q & full & ~pop;
    end
  assign head        = evt_t'(mem_q[rd_q]);
  assign evt_valid   = lvl_q != '0;
  assign evt_release = evt_valid & head.rel;
  assign evt_ext     = evt_valid & head.ext;
  assign evt_scan    = evt_valid ? head.scan : 8'h00;
  assign evt_ascii   = evt_valid ? head.ascii : 8'h00;
  assign mods        = {caps_q, alt_q, ctrl_q, shift_q};
  assign fifo_level  = lvl_q;
  assign overflow    = ovf_q;
endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// tb_ps2_key_event_decoder: directed byte vectors with hand-computed key events
module tb_ps2_key_event_decoder;
  logic clk = 1'b0, rst_n = 1'b0, code_new = 1'b0, evt_ready = 1'b1;
  logic [7:0] code = 8'h00;
  logic evt_valid, evt_release, evt_ext, overflow;
  logic [7:0] evt_scan, evt_ascii;
  logic [3:0] mods, fifo_level;
  int checks = 0, errors = 0, ovf_cnt = 0;
  logic [17:0] got[$];
  typedef struct {
    logic [7:0]  code;
    bit          ev;
    logic [17:0] exp;
    logic [3:0]  mods;
  } vec_t;
  vec_t tbl[$];
  logic [7:0] letters [9] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
  ps2_key_event_decoder dut (
    .clk(clk), .rst_n(rst_n), .ps2_code_new(code_new), .ps2_code(code),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_release(evt_release), .evt_ext(evt_ext),
    .evt_scan(evt_scan), .evt_ascii(evt_ascii), .mods(mods), .fifo_level(fifo_level),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
    if (evt_valid && evt_ready) got.push_back({evt_release, evt_ext, evt_scan, evt_ascii});
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic send(input logic [7:0] c);
    tick;
    code = c;
    code_new = 1'b1;
    tick;
    tick;
    code_new = 1'b0;
    repeat (4) tick;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    rst_n = 1'b1;
    tick;
  endtask
  function automatic vec_t e(logic [7:0] c, logic r, logic x, logic [7:0] s, logic [7:0] a, logic [3:0] m);
    vec_t t;
    t.code = c;
    t.ev = 1'b1;
    t.exp = {r, x, s, a};
    t.mods = m;
    return t;
  endfunction
  function automatic vec_t n(logic [7:0] c, logic [3:0] m);
    vec_t t;
    t.code = c;
    t.ev = 1'b0;
    t.exp = '0;
    t.mods = m;
    return t;
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end
  initial begin
    tbl = '{
      e(8'h1C,0,0,8'h1C,8'h61,4'h0), n(8'hF0,4'h0), e(8'h1C,1,0,8'h1C,8'h61,4'h0),
      n(8'h12,4'h1), e(8'h1C,0,0,8'h1C,8'h41,4'h1), n(8'h1C,4'h1), n(8'h1C,4'h1),
      n(8'hF0,4'h1), e(8'h1C,1,0,8'h1C,8'h41,4'h1), n(8'hF0,4'h1), n(8'h12,4'h0),
      n(8'h58,4'h8), n(8'h58,4'h8), n(8'hF0,4'h8), n(8'h58,4'h8),
      e(8'h1C,0,0,8'h1C,8'h41,4'h8), n(8'hF0,4'h8), e(8'h1C,1,0,8'h1C,8'h41,4'h8),
      e(8'h16,0,0,8'h16,8'h31,4'h8), n(8'hF0,4'h8), e(8'h16,1,0,8'h16,8'h31,4'h8),
      n(8'h14,4'hA), e(8'h1C,0,0,8'h1C,8'h01,4'hA), n(8'hF0,4'hA), e(8'h1C,1,0,8'h1C,8'h01,4'hA),
      n(8'hF0,4'hA), n(8'h14,4'h8), n(8'h58,4'h0), n(8'hF0,4'h0), n(8'h58,4'h0),
      n(8'h11,4'h4), n(8'hF0,4'h4), n(8'h11,4'h0),
      n(8'hE0,4'h0), n(8'h11,4'h4), n(8'hE0,4'h4), n(8'hF0,4'h4), n(8'h11,4'h0),
      n(8'hE0,4'h0), e(8'h75,0,1,8'h75,8'hF5,4'h0), n(8'hE0,4'h0), n(8'hF0,4'h0),
      e(8'h75,1,1,8'h75,8'hF5,4'h0),
      n(8'hE0,4'h0), n(8'hE0,4'h0), e(8'h75,0,1,8'h75,8'hF5,4'h0), n(8'hE0,4'h0), n(8'hF0,4'h0),
      e(8'h75,1,1,8'h75,8'hF5,4'h0),
      n(8'hE1,4'h0), n(8'h14,4'h0), n(8'h77,4'h0), n(8'hE1,4'h0), n(8'hF0,4'h0), n(8'h14,4'h0),
      n(8'hF0,4'h0), n(8'h77,4'h0),
      e(8'h1C,0,0,8'h1C,8'h61,4'h0), n(8'hF0,4'h0), e(8'h1C,1,0,8'h1C,8'h61,4'h0),
      n(8'h59,4'h1), e(8'h16,0,0,8'h16,8'h21,4'h1), n(8'hF0,4'h1), e(8'h16,1,0,8'h16,8'h21,4'h1),
      n(8'hF0,4'h1), n(8'h59,4'h0),
      n(8'hE0,4'h0), n(8'h12,4'h0), n(8'hE0,4'h0), n(8'hF0,4'h0), n(8'h12,4'h0),
      e(8'h05,0,0,8'h05,8'h00,4'h0), e(8'h29,0,0,8'h29,8'h20,4'h0), e(8'h76,0,0,8'h76,8'h1B,4'h0),
      n(8'hF0,4'h0), e(8'h76,1,0,8'h76,8'h1B,4'h0),
      n(8'h12,4'h1), e(8'h4A,0,0,8'h4A,8'h3F,4'h1), n(8'hF0,4'h1), e(8'h4A,1,0,8'h4A,8'h3F,4'h1),
      n(8'hF0,4'h1), n(8'h12,4'h0)
    };
    repeat (2) tick;
    chk("reset outputs", {evt_valid, evt_release, evt_ext, evt_scan, evt_ascii, mods, fifo_level, overflow}, 0);
    rst_n = 1'b1;
    tick;
    foreach (tbl[i]) begin
      got.delete();
      send(tbl[i].code);
      chk($sformatf("row%0d mods", i), mods, tbl[i].mods);
      chk($sformatf("row%0d event count", i), got.size(), tbl[i].ev);
      if (tbl[i].ev && got.size() == 1) chk($sformatf("row%0d event", i), got[0], tbl[i].exp);
    end
    do_reset;
    evt_ready = 1'b0;
    ovf_cnt = 0;
    tick;
    code = 8'h1C;
    code_new = 1'b1;
    @(negedge clk);
    chk("latency strobe cycle valid", evt_valid, 0);
    tick;
    @(negedge clk);
    chk("latency N+1 valid", evt_valid, 0);
    tick;
    @(negedge clk);
    chk("latency N+2 valid", evt_valid, 1);
    chk("latency N+2 level", fifo_level, 1);
    tick;
    code_new = 1'b0;
    repeat (4) tick;
    for (int i = 1; i < 9; i++) send(letters[i]);
    chk("full level", fifo_level, 8);
    chk("overflow pulses", ovf_cnt, 1);
    chk("full head", {evt_valid, evt_release, evt_ext, evt_scan, evt_ascii}, {3'b100, 8'h1C, 8'h61});
    got.delete();
    evt_ready = 1'b1;
    repeat (12) tick;
    chk("drain count", got.size(), 8);
    foreach (got[i]) chk($sformatf("drain scan%0d", i), got[i][15:8], letters[i]);
    chk("drain level", fifo_level, 0);
    send(8'h12);
    chk("pre-reset shift", mods, 1);
    send(8'hF0);
    rst_n = 1'b0;
    #1;
    chk("mid-reset outputs", {evt_valid, evt_release, evt_ext, evt_scan, evt_ascii, mods, fifo_level, overflow}, 0);
    tick;
    rst_n = 1'b1;
    tick;
    got.delete();
    send(8'h1C);
    chk("post-reset event count", got.size(), 1);
    if (got.size() == 1) chk("post-reset event", got[0], {2'b00, 8'h1C, 8'h61});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
